// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
//   Shared definitions for the two-requester memory arbiter:
//   - rw flag encodings carried on the icache, dcache and memory ports
//   - FSM state encoding and the requester identifier
//   - latched memory request record
//   - norm_rw(): folds the 2'b11 request flag onto a plain write
// -----------------------------------------------------------------------------
package mem_arb_pkg;

  localparam logic [1:0] RW_NONE  = 2'b00;
  localparam logic [1:0] RW_READ  = 2'b01;
  localparam logic [1:0] RW_WRITE = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SERV_I = 2'b01,
    SERV_D = 2'b10,
    RESP   = 2'b11
  } arb_state_e;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } requester_e;

  typedef struct packed {
    logic [1:0]  rw_flag;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic [3:0]  write_mask;
  } mem_req_t;

  // A flag with the write bit set is a write, whatever the read bit says.
  function automatic logic [1:0] norm_rw(input logic [1:0] flag);
    return flag[1] ? RW_WRITE : flag;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// -----------------------------------------------------------------------------
// mem_arb_pick
//   Combinational two-way round-robin pick.
//   Ports:
//     req_i, req_d  - icache / dcache currently requesting
//     last_grant    - requester granted most recently
//     grant         - one-hot result: [0] icache, [1] dcache, 2'b00 = none
//   A sole requester always wins; on a tie the one not granted last wins.
// -----------------------------------------------------------------------------
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic       req_i,
  input  logic       req_d,
  input  requester_e last_grant,
  output logic [1:0] grant
);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    grant = 2'b00;
    if (req_i && req_d) begin
      grant = (last_grant == REQ_I) ? 2'b10 : 2'b01;
    end else if (req_i) begin
      grant = 2'b01;
    end else if (req_d) begin
      grant = 2'b10;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares one memory port between an icache and a dcache miss interface.
//   Ports:
//     clk, rst                   - clock, asynchronous active-low reset
//     i_rw_flag/i_addr/i_write_data/i_write_mask - icache request
//     i_read_data/i_busy/i_done  - icache response
//     d_*                        - same set for the dcache
//     mem_rw_flag/mem_addr/mem_write_data/mem_write_mask - memory request
//     mem_read_data/mem_busy/mem_done - memory response
//   One transaction at a time: IDLE grants, SERV_x waits for mem_done,
//   RESP pulses x_done for one cycle and always returns to IDLE.
// -----------------------------------------------------------------------------
module mem_arbiter
  import mem_arb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,

  input  logic [1:0]  i_rw_flag,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_write_data,
  input  logic [3:0]  i_write_mask,
  output logic [31:0] i_read_data,
  output logic        i_busy,
  output logic        i_done,

  input  logic [1:0]  d_rw_flag,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_write_data,
  input  logic [3:0]  d_write_mask,
  output logic [31:0] d_read_data,
  output logic        d_busy,
  output logic        d_done,

  output logic [1:0]  mem_rw_flag,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic [3:0]  mem_write_mask,
  input  logic [31:0] mem_read_data,
  input  logic        mem_busy,
  input  logic        mem_done
);

  arb_state_e  state_q, state_d;
  requester_e  last_grant_q;
  mem_req_t    mem_q;
  logic [31:0] i_read_data_q, d_read_data_q;
  logic        i_busy_q, i_busy_d;
  logic        d_busy_q, d_busy_d;

  logic        req_i, req_d;
  logic [1:0]  grant;
  logic        grant_i, grant_d;

  assign req_i = (i_rw_flag != RW_NONE);
  assign req_d = (d_rw_flag != RW_NONE);

  mem_arb_pick u_pick (
    .req_i      (req_i),
    .req_d      (req_d),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  // Grants only happen from IDLE while memory is free; RESP never grants,
  // so a requester's flag still high in its done cycle is not re-served.
  assign grant_i = (state_q == IDLE) && !mem_busy && grant[0];
  assign grant_d = (state_q == IDLE) && !mem_busy && grant[1];

  // ---------------------------------------------------------------------------
  // FSM next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (grant_i)      state_d = SERV_I;
        else if (grant_d) state_d = SERV_D;
      end
      SERV_I, SERV_D: begin
        if (mem_done) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Busy tracking: raised from the cycle after a request is seen, held while
  // in service, cleared by the edge that ends that requester's RESP cycle.
  // While waiting on the other requester it simply follows the flag.
  // ---------------------------------------------------------------------------
  always_comb begin
    i_busy_d = req_i;
    d_busy_d = req_d;
    if (state_q == RESP && last_grant_q == REQ_I) i_busy_d = 1'b0;
    else if (state_q == SERV_I)                   i_busy_d = 1'b1;
    if (state_q == RESP && last_grant_q == REQ_D) d_busy_d = 1'b0;
    else if (state_q == SERV_D)                   d_busy_d = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: the request and read-data registers are plain flops, not a memory
  // array, so they take the reset too; every output reads 0 while in reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      state_q       <= IDLE;
      last_grant_q  <= REQ_I;
      mem_q         <= '0;
      i_read_data_q <= '0;
      d_read_data_q <= '0;
      i_busy_q      <= 1'b0;
      d_busy_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      i_busy_q <= i_busy_d;
      d_busy_q <= d_busy_d;

      if (grant_i) begin
        mem_q.rw_flag    <= norm_rw(i_rw_flag);
        mem_q.addr       <= i_addr;
        mem_q.write_data <= i_write_data;
        mem_q.write_mask <= i_write_mask;
        last_grant_q     <= REQ_I;
      end else if (grant_d) begin
        mem_q.rw_flag    <= norm_rw(d_rw_flag);
        mem_q.addr       <= d_addr;
        mem_q.write_data <= d_write_data;
        mem_q.write_mask <= d_write_mask;
        last_grant_q     <= REQ_D;
      end

      // Completion: drop the request and, for reads only, keep the data.
      if ((state_q == SERV_I || state_q == SERV_D) && mem_done) begin
        mem_q.rw_flag <= RW_NONE;
        if (mem_q.rw_flag == RW_READ) begin
          if (state_q == SERV_I) i_read_data_q <= mem_read_data;
          else                   d_read_data_q <= mem_read_data;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign mem_rw_flag    = mem_q.rw_flag;
  assign mem_addr       = mem_q.addr;
  assign mem_write_data = mem_q.write_data;
  assign mem_write_mask = mem_q.write_mask;

  // In RESP, last_grant names the requester whose transaction just finished.
  assign i_done      = (state_q == RESP) && (last_grant_q == REQ_I);
  assign d_done      = (state_q == RESP) && (last_grant_q == REQ_D);
  assign i_busy      = i_busy_q;
  assign d_busy      = d_busy_q;
  assign i_read_data = i_read_data_q;
  assign d_read_data = d_read_data_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//   Self-checking bench for mem_arbiter: a per-cycle vector table (inputs
//   driven before an edge, outputs compared 1 time unit after it) followed by
//   hand-written sequences for fairness and mid-transaction reset.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam logic [31:0] I_WDATA = 32'h0BAD_F00D;
  localparam logic [3:0]  I_MASK  = 4'hF;

  logic        clk;
  logic        rst;
  logic [1:0]  i_rw_flag, d_rw_flag, mem_rw_flag;
  logic [31:0] i_addr, i_write_data, i_read_data;
  logic [31:0] d_addr, d_write_data, d_read_data;
  logic [3:0]  i_write_mask, d_write_mask, mem_write_mask;
  logic        i_busy, i_done, d_busy, d_done;
  logic [31:0] mem_addr, mem_write_data, mem_read_data;
  logic        mem_busy, mem_done;

  int n_checks = 0;
  int n_errors = 0;

  mem_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .i_rw_flag      (i_rw_flag),
    .i_addr         (i_addr),
    .i_write_data   (i_write_data),
    .i_write_mask   (i_write_mask),
    .i_read_data    (i_read_data),
    .i_busy         (i_busy),
    .i_done         (i_done),
    .d_rw_flag      (d_rw_flag),
    .d_addr         (d_addr),
    .d_write_data   (d_write_data),
    .d_write_mask   (d_write_mask),
    .d_read_data    (d_read_data),
    .d_busy         (d_busy),
    .d_done         (d_done),
    .mem_rw_flag    (mem_rw_flag),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_write_mask (mem_write_mask),
    .mem_read_data  (mem_read_data),
    .mem_busy       (mem_busy),
    .mem_done       (mem_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_before;
    logic [1:0]  i_rw;
    logic [31:0] i_addr;
    logic [1:0]  d_rw;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_mask;
    logic        m_busy;
    logic        m_done;
    logic [31:0] m_rdata;
    logic [1:0]  e_rw;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [3:0]  e_mask;
    logic        e_ib, e_id, e_db, e_dd;
    logic [31:0] e_ird, e_drd;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t row(
    input logic rb, input logic [1:0] ir, input logic [31:0] ia,
    input logic [1:0] dr, input logic [31:0] da, input logic [31:0] dw,
    input logic [3:0] dm, input logic mb, input logic md, input logic [31:0] mrd,
    input logic [1:0] er, input logic [31:0] ea, input logic [31:0] ew,
    input logic [3:0] em, input logic ib, input logic id, input logic db,
    input logic dd, input logic [31:0] ird, input logic [31:0] drd);
    vec_t v;
    v.rst_before = rb; v.i_rw = ir; v.i_addr = ia;
    v.d_rw = dr; v.d_addr = da; v.d_wdata = dw; v.d_mask = dm;
    v.m_busy = mb; v.m_done = md; v.m_rdata = mrd;
    v.e_rw = er; v.e_addr = ea; v.e_wdata = ew; v.e_mask = em;
    v.e_ib = ib; v.e_id = id; v.e_db = db; v.e_dd = dd;
    v.e_ird = ird; v.e_drd = drd;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    i_rw_flag = 2'b00; i_addr = '0;
    d_rw_flag = 2'b00; d_addr = '0; d_write_data = '0; d_write_mask = '0;
    mem_busy = 1'b0; mem_done = 1'b0; mem_read_data = '0;
  endtask

  // Reset held across one edge, released mid-cycle; the next edge can grant.
  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_rw"},    {30'd0, mem_rw_flag}, 32'd0);
    check({tag, "_mem_addr"},  mem_addr, 32'd0);
    check({tag, "_mem_wdata"}, mem_write_data, 32'd0);
    check({tag, "_mem_mask"},  {28'd0, mem_write_mask}, 32'd0);
    check({tag, "_busy"},      {30'd0, i_busy, d_busy}, 32'd0);
    check({tag, "_done"},      {30'd0, i_done, d_done}, 32'd0);
    check({tag, "_i_rdata"},   i_read_data, 32'd0);
    check({tag, "_d_rdata"},   d_read_data, 32'd0);
  endtask

  initial begin
    logic        found;
    logic        served_d;
    logic [5:0]  exp_order;

    i_write_data = I_WDATA;
    i_write_mask = I_MASK;
    idle_inputs();
    rst = 1'b0;
    #2;
    check_all_zero("por");

    // ---- vector table ------------------------------------------------------
    // Icache read 0x1000, memory done in the 3rd service cycle; address change
    // mid-service ignored; mem_done in IDLE ignored.
    tbl.push_back(row(1, 2'b01, 32'h1000, 2'b00, 0, 0, 0, 0, 0, 0,           2'b01, 32'h1000, I_WDATA, I_MASK, 1, 0, 0, 0, 0, 0));
    tbl.push_back(row(0, 2'b01, 32'h2222, 2'b00, 0, 0, 0, 0, 0, 0,           2'b01, 32'h1000, I_WDATA, I_MASK, 1, 0, 0, 0, 0, 0));
    tbl.push_back(row(0, 2'b01, 32'h1000, 2'b00, 0, 0, 0, 0, 0, 0,           2'b01, 32'h1000, I_WDATA, I_MASK, 1, 0, 0, 0, 0, 0));
    tbl.push_back(row(0, 2'b01, 32'h1000, 2'b00, 0, 0, 0, 0, 1, 32'hDEADBEEF, 2'b00, 0, 0, 0, 1, 1, 0, 0, 32'hDEADBEEF, 0));
    tbl.push_back(row(0, 2'b00, 32'h1000, 2'b00, 0, 0, 0, 0, 0, 0,           2'b00, 0, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 0));
    tbl.push_back(row(0, 2'b00, 32'h0,    2'b00, 0, 0, 0, 0, 1, 32'h11111111, 2'b00, 0, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 0));
    // Simultaneous icache read / dcache write out of reset: dcache first.
    tbl.push_back(row(1, 2'b01, 32'h100, 2'b10, 32'h200, 32'h12345678, 4'b0011, 0, 0, 0,           2'b10, 32'h200, 32'h12345678, 4'b0011, 1, 0, 1, 0, 0, 0));
    tbl.push_back(row(0, 2'b01, 32'h100, 2'b10, 32'h200, 32'h12345678, 4'b0011, 0, 1, 32'hFFFF0000, 2'b00, 0, 0, 0, 1, 0, 1, 1, 0, 0));
    tbl.push_back(row(0, 2'b01, 32'h100, 2'b00, 0, 0, 0, 0, 0, 0,                                  2'b00, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(row(0, 2'b01, 32'h100, 2'b00, 0, 0, 0, 0, 0, 0,                                  2'b01, 32'h100, I_WDATA, I_MASK, 1, 0, 0, 0, 0, 0));
    tbl.push_back(row(0, 2'b01, 32'h100, 2'b00, 0, 0, 0, 0, 1, 32'hA5A50001,                       2'b00, 0, 0, 0, 1, 1, 0, 0, 32'hA5A50001, 0));
    tbl.push_back(row(0, 2'b00, 32'h0,   2'b00, 0, 0, 0, 0, 0, 0,                                  2'b00, 0, 0, 0, 0, 0, 0, 0, 32'hA5A50001, 0));
    // mem_busy high for 4 cycles blocks the grant.
    for (int k = 0; k < 4; k++)
      tbl.push_back(row(k == 0, 2'b01, 32'h40, 2'b00, 0, 0, 0, 1, 0, 0,      2'b00, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(row(0, 2'b01, 32'h40, 2'b00, 0, 0, 0, 0, 0, 0,             2'b01, 32'h40, I_WDATA, I_MASK, 1, 0, 0, 0, 0, 0));
    tbl.push_back(row(0, 2'b01, 32'h40, 2'b00, 0, 0, 0, 0, 1, 32'h0C0C0C0C,  2'b00, 0, 0, 0, 1, 1, 0, 0, 32'h0C0C0C0C, 0));
    tbl.push_back(row(0, 2'b00, 32'h0,  2'b00, 0, 0, 0, 0, 0, 0,             2'b00, 0, 0, 0, 0, 0, 0, 0, 32'h0C0C0C0C, 0));
    // Dcache flag 2'b11 forwarded as write; write leaves d_read_data alone.
    tbl.push_back(row(1, 2'b00, 0, 2'b11, 32'h300, 32'hCAFEF00D, 4'b1000, 0, 0, 0,           2'b10, 32'h300, 32'hCAFEF00D, 4'b1000, 0, 0, 1, 0, 0, 0));
    tbl.push_back(row(0, 2'b00, 0, 2'b11, 32'h300, 32'hCAFEF00D, 4'b1000, 0, 1, 32'h99999999, 2'b00, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    tbl.push_back(row(0, 2'b00, 0, 2'b00, 0, 0, 0, 0, 0, 0,                                  2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // Dcache read.
    tbl.push_back(row(0, 2'b00, 0, 2'b01, 32'h400, 0, 0, 0, 0, 0,            2'b01, 32'h400, 0, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(row(0, 2'b00, 0, 2'b01, 32'h400, 0, 0, 0, 1, 32'h77770000, 2'b00, 0, 0, 0, 0, 0, 1, 1, 0, 32'h77770000));
    tbl.push_back(row(0, 2'b00, 0, 2'b00, 0, 0, 0, 0, 0, 0,                  2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 32'h77770000));

    foreach (tbl[n]) begin
      if (tbl[n].rst_before) do_reset();
      i_rw_flag = tbl[n].i_rw;   i_addr = tbl[n].i_addr;
      d_rw_flag = tbl[n].d_rw;   d_addr = tbl[n].d_addr;
      d_write_data = tbl[n].d_wdata; d_write_mask = tbl[n].d_mask;
      mem_busy = tbl[n].m_busy;  mem_done = tbl[n].m_done;
      mem_read_data = tbl[n].m_rdata;
      @(posedge clk);
      #1;
      check($sformatf("v%0d_mem_rw", n), {30'd0, mem_rw_flag}, {30'd0, tbl[n].e_rw});
      if (tbl[n].e_rw != 2'b00) begin
        check($sformatf("v%0d_mem_addr", n),  mem_addr, tbl[n].e_addr);
        check($sformatf("v%0d_mem_wdata", n), mem_write_data, tbl[n].e_wdata);
        check($sformatf("v%0d_mem_mask", n),  {28'd0, mem_write_mask}, {28'd0, tbl[n].e_mask});
      end
      check($sformatf("v%0d_i_busy", n),  {31'd0, i_busy}, {31'd0, tbl[n].e_ib});
      check($sformatf("v%0d_i_done", n),  {31'd0, i_done}, {31'd0, tbl[n].e_id});
      check($sformatf("v%0d_d_busy", n),  {31'd0, d_busy}, {31'd0, tbl[n].e_db});
      check($sformatf("v%0d_d_done", n),  {31'd0, d_done}, {31'd0, tbl[n].e_dd});
      check($sformatf("v%0d_i_rdata", n), i_read_data, tbl[n].e_ird);
      check($sformatf("v%0d_d_rdata", n), d_read_data, tbl[n].e_drd);
    end

    // ---- reset mid-SERV_D (d_read_data holds 0x77770000 beforehand) --------
    mem_done = 1'b0;
    d_rw_flag = 2'b01; d_addr = 32'h500;
    @(posedge clk);
    #1;
    check("rst_mid_serving", {30'd0, mem_rw_flag}, 32'd1);
    check("rst_mid_rdata_before", d_read_data, 32'h77770000);
    #2 rst = 1'b0;
    #1;
    check_all_zero("rst_async");
    d_rw_flag = 2'b00;
    mem_done = 1'b1; mem_read_data = 32'h5555AAAA;
    @(posedge clk);
    #1;
    check("rst_held_no_done", {31'd0, d_done}, 32'd0);
    rst = 1'b1;
    mem_done = 1'b0;
    @(posedge clk);
    #1;
    check("rst_after_no_done", {31'd0, d_done}, 32'd0);
    check("rst_after_idle", {30'd0, mem_rw_flag}, 32'd0);
    d_rw_flag = 2'b10; d_addr = 32'h600; d_write_data = 32'h1; d_write_mask = 4'hF;
    @(posedge clk);
    #1;
    check("rst_regrant_rw", {30'd0, mem_rw_flag}, 32'd2);
    check("rst_regrant_addr", mem_addr, 32'h600);
    mem_done = 1'b1;
    @(posedge clk);
    #1;
    mem_done = 1'b0;
    check("rst_regrant_done", {31'd0, d_done}, 32'd1);
    d_rw_flag = 2'b00;
    @(posedge clk);
    #1;

    // ---- fairness: both requesting continuously, order D I D I D I ---------
    do_reset();
    exp_order = 6'b010101;   // bit k = 1 means dcache expected for grant k
    i_rw_flag = 2'b01; i_addr = 32'h1100;
    d_rw_flag = 2'b01; d_addr = 32'h2200;
    for (int k = 0; k < 6; k++) begin
      found = 1'b0;
      for (int c = 0; c < 10 && !found; c++) begin
        @(posedge clk);
        #1;
        if (mem_rw_flag != 2'b00) found = 1'b1;
      end
      check($sformatf("fair%0d_granted", k), {31'd0, found}, 32'd1);
      served_d = (mem_addr == 32'h2200);
      check($sformatf("fair%0d_order", k), {31'd0, served_d}, {31'd0, exp_order[k]});
      mem_done = 1'b1; mem_read_data = 32'hF000 + k;
      @(posedge clk);
      #1;
      mem_done = 1'b0;
      check($sformatf("fair%0d_done", k), {30'd0, d_done, i_done},
            exp_order[k] ? 32'd2 : 32'd1);
      if (served_d) d_rw_flag = 2'b00; else i_rw_flag = 2'b00;
      @(posedge clk);
      #1;
      i_rw_flag = 2'b01;
      d_rw_flag = 2'b01;
    end
    idle_inputs();
    @(posedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
